game_event_timer: RTL

Periodic event generator that consumes the free-running 32-bit `gameTime` count produced by the game clock and turns it into handshaked game events such as alien-march steps and bomb drops. Software programs a period. The block tracks an absolute deadline in `gameTime` units, raises `event_valid` with a timestamp when the deadline passes, and holds it until acknowledged. Deadlines that pass while an event is still unacknowledged are counted, not queued.

---
 rtl/game_event_timer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/game_event_timer.sv
// Periodic game event generator tracking an absolute deadline in gameTime units.
// Events are handshaked; deadlines passing while an event is pending are counted.
module game_event_timer #(
  parameter int MISS_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       gameTime,
  input  logic              cfg_enable,
  input  logic              cfg_write,
  input  logic [31:0]       cfg_period,
  output logic              event_valid,
  input  logic              event_ack,
  output logic [31:0]       event_time,
  output logic [MISS_W-1:0] missed_count,
  output logic              armed
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_PEND
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [31:0]         r_period;
  logic [31:0]         r_deadline;
  logic                r_valid;
  logic [31:0]         r_time;
  logic [MISS_W-1:0]   r_missed;

  logic [31:0]         w_period_nxt;
  logic [31:0]         w_deadline_nxt;
  logic                w_valid_nxt;
  logic [31:0]         w_time_nxt;
  logic [MISS_W-1:0]   w_missed_nxt;

  logic [31:0]         w_diff;
  logic                w_due;
  logic                w_load;
  logic [31:0]         w_dl_step;
  logic [MISS_W-1:0]   w_missed_inc;

  // Signed difference keeps the deadline compare correct across 2^32 wrap.
  assign w_diff       = gameTime - r_deadline;
  assign w_due        = ($signed(w_diff) >= 0);
  assign w_load       = cfg_write && (cfg_period != 32'd0);
  assign w_dl_step    = r_deadline + r_period;
  assign w_missed_inc = (r_missed == {MISS_W{1'b1}}) ?
                        r_missed : r_missed + MISS_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_period_nxt   = r_period;
    w_deadline_nxt = r_deadline;
    w_valid_nxt    = r_valid;
    w_time_nxt     = r_time;
    w_missed_nxt   = r_missed;
    if (!cfg_enable) begin
      w_state_nxt = S_IDLE;
      w_valid_nxt = 1'b0;
    end else if (w_load) begin
      w_state_nxt    = S_ARMED;
      w_period_nxt   = cfg_period;
      w_deadline_nxt = gameTime + cfg_period;
      w_valid_nxt    = 1'b0;
      w_missed_nxt   = '0;
    end else begin
      unique case (r_state)
        S_ARMED: begin
          if (w_due) begin
            w_state_nxt    = S_PEND;
            w_valid_nxt    = 1'b1;
            w_time_nxt     = r_deadline;
            w_deadline_nxt = w_dl_step;
          end
        end
        S_PEND: begin
          if (event_ack && w_due) begin
            w_time_nxt     = r_deadline;
            w_deadline_nxt = w_dl_step;
          end else if (event_ack) begin
            w_state_nxt = S_ARMED;
            w_valid_nxt = 1'b0;
          end else if (w_due) begin
            w_deadline_nxt = w_dl_step;
            w_missed_nxt   = w_missed_inc;
          end
        end
        default: begin
          w_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_period   <= 32'd0;
      r_deadline <= 32'd0;
      r_valid    <= 1'b0;
      r_time     <= 32'd0;
      r_missed   <= '0;
    end else begin
      r_period   <= w_period_nxt;
      r_deadline <= w_deadline_nxt;
      r_valid    <= w_valid_nxt;
      r_time     <= w_time_nxt;
      r_missed   <= w_missed_nxt;
    end
  end

  always_comb begin
    armed        = (r_state != S_IDLE);
    event_valid  = r_valid;
    event_time   = r_time;
    missed_count = r_missed;
  end

endmodule
